// File: rtl/neuron_dp_ram_if.sv
// Bus bundle for neuron_dp_ram: one write port, one registered read port, and init status.
// The master drives addresses, data and enables; the slave (the RAM) returns read_data and init_done.
interface neuron_dp_ram_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] read_address;
   logic [ADDR_WIDTH-1:0] write_address;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  oe;
   logic                  wre;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  init_done;

   modport master (
      output read_address, write_address, write_data, oe, wre,
      input  read_data, init_done
   );

   modport slave (
      input  read_address, write_address, write_data, oe, wre,
      output read_data, init_done
   );
endinterface

// File: rtl/neuron_dp_ram.sv
// Simple dual-port RAM for neuron weights/activations with a post-reset clear sequencer.
// Build option: define NEURON_DP_RAM_BYPASS_EN for write-first collisions (default is read-first).
module neuron_dp_ram #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   neuron_dp_ram_if.slave bus
);

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_t                state_q;
   state_t                state_d;
   logic [ADDR_WIDTH-1:0] clr_ptr_q;
   logic                  clearing;
   logic                  last_clear;
   logic                  do_write;
   logic                  collision;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign last_clear = (clr_ptr_q == LAST_ADDR);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         CLEAR:   if (last_clear) state_d = READY;
         READY:   state_d = READY;
         default: state_d = CLEAR;
      endcase
   end

   always_comb begin
      clearing      = (state_q == CLEAR);
      bus.init_done = (state_q == READY);
   end

   always_ff @(posedge clk) begin
      if (rst || !clearing) begin
         clr_ptr_q <= '0;
      end else begin
         clr_ptr_q <= clr_ptr_q + 1'b1;
      end
   end

   assign do_write  = !rst && !clearing && bus.wre;
   assign collision = do_write && (bus.read_address == bus.write_address);

   // NOTE: the array has no reset branch so it maps onto block RAM; the clear sequencer zeroes it instead.
   always_ff @(posedge clk) begin
      if (!rst && clearing) begin
         mem[clr_ptr_q] <= '0;
      end else if (do_write) begin
         mem[bus.write_address] <= bus.write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clearing || !bus.oe) begin
         bus.read_data <= '0;
      end else begin
`ifdef NEURON_DP_RAM_BYPASS_EN
         bus.read_data <= collision ? bus.write_data : mem[bus.read_address];
`else
         bus.read_data <= mem[bus.read_address];
`endif
      end
   end

`ifndef NEURON_DP_RAM_BYPASS_EN
   // Read-first: the old word is returned on a collision, so the flag has no consumer here.
   logic unused_collision;
   assign unused_collision = collision;
`endif

endmodule

// File: tb/tb_neuron_dp_ram.sv
// Directed self-checking bench for neuron_dp_ram: clear timing, read/write, oe, back-to-back, collision, mid-clear reset.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_neuron_dp_ram;

   localparam int AW = 8;
   localparam int DW = 8;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   n;
   int   bad_rd;

   neuron_dp_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   neuron_dp_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Counts edges until init_done rises (bounded) and tallies nonzero read_data seen while clearing.
   task automatic wait_init(output int edges, output int nonzero);
      edges   = 0;
      nonzero = 0;
      while (edges < 300) begin
         step();
         edges++;
         if (bus.read_data !== 8'h00) nonzero++;
         if (bus.init_done === 1'b1) break;
      end
   endtask

   logic [7:0] coll_exp;

   initial begin
      checks = 0;
      errors = 0;
`ifdef NEURON_DP_RAM_BYPASS_EN
      coll_exp = 8'h7F;
`else
      coll_exp = 8'h10;
`endif
      rst               = 1'b1;
      bus.oe            = 1'b0;
      bus.wre           = 1'b0;
      bus.read_address  = '0;
      bus.write_address = '0;
      bus.write_data    = '0;
      step();
      step();
      check("reset_read_data", bus.read_data, 8'h00);
      check("reset_init_done", bus.init_done, 1'b0);

      // Clear with oe/wre held high: the write must be ignored and read_data stay 0.
      bus.oe            = 1'b1;
      bus.wre           = 1'b1;
      bus.write_address = 8'd5;
      bus.write_data    = 8'hAA;
      bus.read_address  = 8'd5;
      rst               = 1'b0;
      wait_init(n, bad_rd);
      check("clear_latency", n, 256);
      check("clear_read_zero", bad_rd, 0);

      bus.wre = 1'b0;
      bus.read_address = 8'd0;   step(); check("cleared_addr0", bus.read_data, 8'h00);
      bus.read_address = 8'd5;   step(); check("cleared_addr5", bus.read_data, 8'h00);
      bus.read_address = 8'd255; step(); check("cleared_addr255", bus.read_data, 8'h00);

      // Basic write then read, plus output enable.
      bus.oe = 1'b0; bus.wre = 1'b1; bus.write_address = 8'd2; bus.write_data = 8'h03;
      step(); check("oe_low_during_write", bus.read_data, 8'h00);
      bus.wre = 1'b0; bus.oe = 1'b1; bus.read_address = 8'd2;
      step(); check("read_addr2", bus.read_data, 8'h03);
      bus.read_address = 8'd0;
      step(); check("read_addr0", bus.read_data, 8'h00);
      bus.read_address = 8'd2;
      step(); check("read_addr2_again", bus.read_data, 8'h03);
      bus.oe = 1'b0;
      step(); check("oe_low", bus.read_data, 8'h00);
      bus.oe = 1'b1;
      step(); check("oe_high_again", bus.read_data, 8'h03);

      // Back-to-back writes and reads.
      bus.oe = 1'b0; bus.wre = 1'b1;
      bus.write_address = 8'd0;   bus.write_data = 8'h11; step();
      bus.write_address = 8'd1;   bus.write_data = 8'h22; step();
      bus.write_address = 8'd255; bus.write_data = 8'h33; step();
      bus.wre = 1'b0; bus.oe = 1'b1;
      bus.read_address = 8'd255; step(); check("b2b_255", bus.read_data, 8'h33);
      bus.read_address = 8'd1;   step(); check("b2b_1", bus.read_data, 8'h22);
      bus.read_address = 8'd0;   step(); check("b2b_0", bus.read_data, 8'h11);

      // Non-colliding simultaneous write/read.
      bus.wre = 1'b1; bus.write_address = 8'd9; bus.write_data = 8'h5A; bus.read_address = 8'd1;
      step(); check("no_collision_read", bus.read_data, 8'h22);

      // Collision on address 7.
      bus.oe = 1'b0; bus.write_address = 8'd7; bus.write_data = 8'h10;
      step();
      bus.oe = 1'b1; bus.read_address = 8'd7; bus.write_data = 8'h7F;
      step(); check("collision_read", bus.read_data, coll_exp);
      bus.wre = 1'b0;
      step(); check("after_collision", bus.read_data, 8'h7F);
      bus.read_address = 8'd9;
      step(); check("read_addr9", bus.read_data, 8'h5A);

      // Reset 100 cycles into a clear restarts the sequence from address 0.
      rst = 1'b1;
      step();
      check("rst_read_data", bus.read_data, 8'h00);
      check("rst_init_done", bus.init_done, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 100; i++) step();
      check("mid_clear_init_done", bus.init_done, 1'b0);
      rst = 1'b1;
      bus.wre = 1'b1; bus.write_address = 8'd7; bus.write_data = 8'hEE;
      step();
      rst = 1'b0;
      wait_init(n, bad_rd);
      check("reclear_latency", n, 256);
      check("reclear_read_zero", bad_rd, 0);
      bus.wre = 1'b0;
      bus.read_address = 8'd7;   step(); check("recleared_addr7", bus.read_data, 8'h00);
      bus.read_address = 8'd255; step(); check("recleared_addr255", bus.read_data, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
